// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: default widths, stack-pointer reset value,
// opcode and FSM state enums, and small opcode-classification helpers.
package mem_stage_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 11;
  localparam logic [ADDR_W-1:0] SP_RESET = 11'h7FF;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LDM  = 3'd1,
    OP_LDD  = 3'd2,
    OP_STD  = 3'd3,
    OP_PUSH = 3'd4,
    OP_POP  = 3'd5
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Ops that need a data-memory transaction; codes 6 and 7 fall through as illegal.
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LDD) || (op == OP_STD) || (op == OP_PUSH) || (op == OP_POP);
  endfunction

  function automatic logic is_load_op(input logic [2:0] op);
    return (op == OP_LDD) || (op == OP_POP);
  endfunction

  function automatic logic is_write_op(input logic [2:0] op);
    return (op == OP_STD) || (op == OP_PUSH);
  endfunction

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer register with modulo 2^ADDR_W increment/decrement.
// Exposes both sp (PUSH address) and sp+1 (POP address).
module stack_ptr
  import mem_stage_pkg::*;
#(
  parameter int                ADDR_W   = mem_stage_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] SP_RESET = mem_stage_pkg::SP_RESET
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_plus1
);

  logic [ADDR_W-1:0] sp_minus1;

  assign sp_plus1  = sp + 1'b1;
  assign sp_minus1 = sp - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= SP_RESET;
    end else if (inc) begin
      sp <= sp_plus1;
    end else if (dec) begin
      sp <= sp_minus1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: executes LDM/NOP in one cycle and LDD/STD/PUSH/POP through a
// registered request/ack handshake with the data memory, then pulses a writeback record.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int                DATA_W   = mem_stage_pkg::DATA_W,
  parameter int                ADDR_W   = mem_stage_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] SP_RESET = mem_stage_pkg::SP_RESET
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_value,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [2:0]        in_rdst,
  input  logic [2:0]        in_ccr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic              out_wb_en,
  output logic [2:0]        out_rdst,
  output logic [DATA_W-1:0] out_result,
  output logic [2:0]        out_ccr,
  output logic [ADDR_W-1:0] sp
);

  state_e            state, state_next;
  logic              accept;
  logic              accept_mem;
  logic              accept_alu;
  logic              done;
  logic [2:0]        op_q;
  logic [2:0]        rdst_q;
  logic [2:0]        ccr_q;
  logic [ADDR_W-1:0] sp_plus1;
  logic              sp_inc;
  logic              sp_dec;

  assign in_ready   = (state == ST_IDLE);
  assign accept     = in_valid && in_ready;
  assign accept_mem = accept && is_mem_op(in_op);
  assign accept_alu = accept && !is_mem_op(in_op);
  // An ack only means something while a request is outstanding.
  assign done       = (state == ST_WAIT) && mem_ack;

  assign sp_inc = done && (op_q == OP_POP);
  assign sp_dec = done && (op_q == OP_PUSH);

  stack_ptr #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_stack_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .sp       (sp),
    .sp_plus1 (sp_plus1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept_mem) state_next = ST_WAIT;
      ST_WAIT: if (mem_ack)    state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields are loaded once at acceptance and held untouched for the whole wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept_mem) begin
      mem_req <= 1'b1;
      mem_we  <= is_write_op(in_op);
      case (in_op)
        OP_PUSH: begin
          mem_addr  <= sp;
          mem_wdata <= in_value;
        end
        OP_POP: begin
          mem_addr  <= sp_plus1;
          mem_wdata <= '0;
        end
        OP_STD: begin
          mem_addr  <= in_value[ADDR_W-1:0];
          mem_wdata <= in_store_data;
        end
        default: begin
          mem_addr  <= in_value[ADDR_W-1:0];
          mem_wdata <= '0;
        end
      endcase
    end else if (done) begin
      mem_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_NOP;
      rdst_q <= '0;
      ccr_q  <= '0;
    end else if (accept_mem) begin
      op_q   <= in_op;
      rdst_q <= in_rdst;
      ccr_q  <= in_ccr;
    end
  end

  // out_valid is a single-cycle pulse; the payload simply holds until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_wb_en  <= 1'b0;
      out_rdst   <= '0;
      out_result <= '0;
      out_ccr    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept_alu) begin
        out_valid  <= 1'b1;
        out_wb_en  <= (in_op == OP_LDM);
        out_result <= (in_op == OP_LDM) ? in_value : '0;
        out_rdst   <= in_rdst;
        out_ccr    <= in_ccr;
      end else if (done) begin
        out_valid  <= 1'b1;
        out_wb_en  <= is_load_op(op_q);
        out_result <= is_load_op(op_q) ? mem_rdata : '0;
        out_rdst   <= rdst_q;
        out_ccr    <= ccr_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random op streams checked
// against a behavioural stack/memory model, with the bench acting as the data memory.
module tb_mem_stage;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 11;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_value;
  logic [DATA_W-1:0] in_store_data;
  logic [2:0]        in_rdst;
  logic [2:0]        in_ccr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_wb_en;
  logic [2:0]        out_rdst;
  logic [DATA_W-1:0] out_result;
  logic [2:0]        out_ccr;
  logic [ADDR_W-1:0] sp;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] ref_sp;

  mem_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_value      (in_value),
    .in_store_data (in_store_data),
    .in_rdst       (in_rdst),
    .in_ccr        (in_ccr),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_wb_en     (out_wb_en),
    .out_rdst      (out_rdst),
    .out_result    (out_result),
    .out_ccr       (out_ccr),
    .sp            (sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleQuiet(input string tag);
    checkOutput({tag, " out_valid"}, out_valid, 1'b0);
    checkOutput({tag, " mem_req"}, mem_req, 1'b0);
    checkOutput({tag, " sp"}, sp, ref_sp);
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    mem_ack  = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    checkOutput("rst sp", sp, 11'h7FF);
    checkOutput("rst in_ready", in_ready, 1'b1);
    checkOutput("rst mem_req", mem_req, 1'b0);
    checkOutput("rst mem_we", mem_we, 1'b0);
    checkOutput("rst mem_addr", mem_addr, 0);
    checkOutput("rst mem_wdata", mem_wdata, 0);
    checkOutput("rst out_valid", out_valid, 1'b0);
    checkOutput("rst out_wb_en", out_wb_en, 1'b0);
    checkOutput("rst out_rdst", out_rdst, 0);
    checkOutput("rst out_result", out_result, 0);
    checkOutput("rst out_ccr", out_ccr, 0);
    rst_n  = 1'b1;
    ref_sp = 11'h7FF;
    @(negedge clk);
  endtask

  // Idle cycles, optionally with a stray ack that must be ignored.
  task automatic idleCycles(input int n, input logic ack);
    for (int i = 0; i < n; i++) begin
      mem_ack = ack;
      @(negedge clk);
      checkIdleQuiet("idle");
      checkOutput("idle in_ready", in_ready, 1'b1);
    end
    mem_ack = 1'b0;
  endtask

  // Issues one instruction at the current negedge and follows it to its out_valid pulse.
  // Returns on the pulse cycle so the next call can issue back-to-back.
  task automatic applyStimulus(input logic [2:0] op, input logic [DATA_W-1:0] value,
                               input logic [DATA_W-1:0] sdata, input logic [2:0] rdst,
                               input logic [2:0] ccr, input int req_cycles);
    logic              is_mem, exp_we, exp_wb;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata, exp_result;
    is_mem     = (op >= 3'd2) && (op <= 3'd5);
    exp_we     = (op == 3'd3) || (op == 3'd4);
    exp_wb     = (op == 3'd1) || (op == 3'd2) || (op == 3'd5);
    exp_addr   = '0;
    exp_wdata  = '0;
    exp_result = '0;
    case (op)
      3'd1: exp_result = value;
      3'd2: begin exp_addr = value[ADDR_W-1:0]; exp_result = mem[exp_addr]; end
      3'd3: begin exp_addr = value[ADDR_W-1:0]; exp_wdata = sdata; end
      3'd4: begin exp_addr = ref_sp; exp_wdata = value; end
      3'd5: begin exp_addr = ref_sp + 11'd1; exp_result = mem[exp_addr]; end
      default: ;
    endcase

    checkOutput("issue in_ready", in_ready, 1'b1);
    in_valid      = 1'b1;
    in_op         = op;
    in_value      = value;
    in_store_data = sdata;
    in_rdst       = rdst;
    in_ccr        = ccr;
    @(negedge clk);
    in_valid      = 1'b0;
    in_op         = 3'($urandom);
    in_value      = 16'($urandom);
    in_store_data = 16'($urandom);
    in_rdst       = 3'($urandom);
    in_ccr        = 3'($urandom);

    if (is_mem) begin
      for (int c = 0; c < req_cycles; c++) begin
        checkOutput("wait mem_req", mem_req, 1'b1);
        checkOutput("wait in_ready", in_ready, 1'b0);
        checkOutput("wait out_valid", out_valid, 1'b0);
        checkOutput("wait mem_we", mem_we, exp_we);
        checkOutput("wait mem_addr", mem_addr, exp_addr);
        if (exp_we) checkOutput("wait mem_wdata", mem_wdata, exp_wdata);
        checkOutput("wait sp", sp, ref_sp);
        if (c == req_cycles - 1) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem[mem_addr];
        end else begin
          mem_rdata = 16'($urandom);
        end
        @(negedge clk);
      end
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
      if (op == 3'd4) ref_sp = ref_sp - 11'd1;
      if (op == 3'd5) ref_sp = ref_sp + 11'd1;
    end

    checkOutput("done out_valid", out_valid, 1'b1);
    checkOutput("done out_wb_en", out_wb_en, exp_wb);
    checkOutput("done out_result", out_result, exp_result);
    checkOutput("done out_rdst", out_rdst, rdst);
    checkOutput("done out_ccr", out_ccr, ccr);
    checkOutput("done mem_req", mem_req, 1'b0);
    checkOutput("done sp", sp, ref_sp);
  endtask

  initial begin
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_val;

    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 16'($urandom);
    in_valid      = 1'b0;
    in_op         = 3'd0;
    in_value      = '0;
    in_store_data = '0;
    in_rdst       = '0;
    in_ccr        = '0;
    mem_ack       = 1'b0;
    mem_rdata     = '0;
    rst_n         = 1'b1;
    ref_sp        = 11'h7FF;
    #2;
    doReset();

    $display("[TB] LDM immediate");
    applyStimulus(3'd1, 16'hBEEF, 16'h0000, 3'd3, 3'b101, 0);

    $display("[TB] STD with slow ack then LDD back-to-back");
    applyStimulus(3'd3, 16'h0010, 16'h1234, 3'd1, 3'b010, 3);
    applyStimulus(3'd2, 16'h0010, 16'h0000, 3'd2, 3'b001, 1);
    checkOutput("ldd after std", out_result, 16'h1234);

    $display("[TB] PUSH then POP");
    applyStimulus(3'd4, 16'hAAAA, 16'h0000, 3'd4, 3'b011, 1);
    checkOutput("push sp", sp, 11'h7FE);
    applyStimulus(3'd5, 16'h0000, 16'h0000, 3'd5, 3'b100, 2);
    checkOutput("pop sp", sp, 11'h7FF);
    checkOutput("pop result", out_result, 16'hAAAA);

    $display("[TB] illegal ops and NOP");
    applyStimulus(3'd7, 16'h5555, 16'h0000, 3'd6, 3'b111, 0);
    applyStimulus(3'd6, 16'h1111, 16'h0000, 3'd7, 3'b000, 0);
    applyStimulus(3'd0, 16'h2222, 16'h0000, 3'd1, 3'b110, 0);
    idleCycles(2, 1'b0);

    $display("[TB] POP directly after reset wraps");
    doReset();
    applyStimulus(3'd5, 16'h0000, 16'h0000, 3'd2, 3'b001, 1);
    checkOutput("pop wrap sp", sp, 11'h000);
    applyStimulus(3'd4, 16'h7777, 16'h0000, 3'd3, 3'b010, 1);
    checkOutput("push wrap sp", sp, 11'h7FF);

    $display("[TB] random op stream");
    for (int n = 0; n < 120; n++) begin
      r_op  = 3'($urandom_range(0, 7));
      r_val = 16'($urandom);
      if (r_op == 3'd2 || r_op == 3'd3) r_val[ADDR_W-1:0] = 11'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2), 1'($urandom));
      applyStimulus(r_op, r_val, 16'($urandom), 3'($urandom), 3'($urandom),
                    $urandom_range(1, 4));
    end

    $display("[TB] stray ack in idle, then reset during wait");
    idleCycles(4, 1'b1);
    in_valid = 1'b1;
    in_op    = 3'd2;
    in_value = 16'h0020;
    in_rdst  = 3'd1;
    in_ccr   = 3'b001;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("abort mem_req before", mem_req, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort mem_req async", mem_req, 1'b0);
    checkOutput("abort sp", sp, 11'h7FF);
    checkOutput("abort out_valid", out_valid, 1'b0);
    checkOutput("abort in_ready", in_ready, 1'b1);
    ref_sp = 11'h7FF;
    @(negedge clk);
    mem_ack = 1'b1;
    rst_n   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkIdleQuiet("late ack");
    end
    mem_ack = 1'b0;
    applyStimulus(3'd1, 16'h0F0F, 16'h0000, 3'd5, 3'b010, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DATA_W, default 16: data and result width.
REQ-002 Parameter ADDR_W, default 11: data-memory word-address width.
REQ-003 Parameter SP_RESET, default 11'h7FF: stack-pointer reset value.
REQ-004 Clocking SHALL be one clock, and reset SHALL be asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  upstream (execute) holds a memory-class instruction.
REQ-008 in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready at a clock edge.
REQ-009 in_op  in  3  0 NOP, 1 LDM, 2 LDD, 3 STD, 4 PUSH, 5 POP; 6 and 7 illegal.
REQ-010 in_value  in  DATA_W  LDM immediate / LDD-STD effective address / PUSH data.
REQ-011 in_store_data  in  DATA_W  STD write data.
REQ-012 in_rdst  in  3  destination register index.
REQ-013 in_ccr  in  3  flags from execute, passed through unchanged.
REQ-014 mem_req  out  1  memory request, held until acknowledged.
REQ-015 mem_we  out  1  1 write, 0 read; valid while mem_req.
REQ-016 mem_addr  out  ADDR_W  word address; valid while mem_req.
REQ-017 mem_wdata  out  DATA_W  write data; valid while mem_req && mem_we.
REQ-018 mem_ack  in  1  one-cycle completion pulse; mem_rdata is valid in the same cycle.
REQ-019 mem_rdata  in  DATA_W  read data.
REQ-020 out_valid  out  1  one-cycle pulse carrying a completed instruction to writeback.
REQ-021 out_wb_en  out  1  writeback of out_result to out_rdst is required.
REQ-022 out_rdst  out  3 / out_result  out  DATA_W / out_ccr  out  3  writeback payload.
REQ-023 sp  out  ADDR_W  current stack pointer.

Function
REQ-024 The FSM SHALL have exactly two states: IDLE and WAIT. in_ready SHALL be 1 exactly in IDLE.
REQ-025 Accepting NOP, LDM, or an illegal op SHALL keep the FSM in IDLE; out_valid SHALL pulse on the next cycle.
REQ-026 For LDM, out_result SHALL be in_value and out_wb_en SHALL be 1; for NOP and illegal ops, out_wb_en SHALL be 0 and out_result SHALL be 0.
REQ-027 Accepting LDD, STD, PUSH, or POP SHALL move the FSM to WAIT, asserting mem_req from the next cycle until the cycle mem_ack is seen, inclusive.
REQ-028 mem_req, mem_we, mem_addr, and mem_wdata SHALL be registered and SHALL stay stable throughout WAIT.
REQ-029 LDD: read at in_value[ADDR_W-1:0]. STD: write in_store_data at in_value[ADDR_W-1:0].
REQ-030 PUSH: write in_value at sp, then sp <= sp-1 on ack (post-decrement).
REQ-031 POP: read at sp+1, then sp <= sp+1 on ack (pre-increment).
REQ-032 sp arithmetic SHALL be modulo 2^ADDR_W: a POP at 11'h7FF reads address 0, and a PUSH at 0 leaves sp = 11'h7FF.
REQ-033 sp SHALL change only on the mem_ack that completes a PUSH or POP.
REQ-034 On mem_ack in WAIT, the FSM SHALL return to IDLE, and out_valid SHALL pulse on the following cycle.
REQ-035 For that pulse, out_result SHALL be the captured mem_rdata for LDD and POP (out_wb_en = 1), and 0 for STD and PUSH (out_wb_en = 0).
REQ-036 out_rdst and out_ccr SHALL equal the in_rdst and in_ccr captured at acceptance, for every op.
REQ-037 mem_ack while in IDLE SHALL be ignored.
REQ-038 Minimum memory-op latency SHALL be 2 cycles from acceptance to out_valid (ack arriving in the first WAIT cycle); maximum latency is unbounded.
REQ-039 A new instruction SHALL be accepted in the same cycle that out_valid of the previous one pulses.
REQ-040 Writeback never back-pressures this stage.

Reset
REQ-041 While rst_n = 0, outputs SHALL be: state IDLE, sp = SP_RESET, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, out_valid = 0, out_wb_en = 0, out_rdst = 0, out_result = 0, out_ccr = 0.
REQ-042 Reset asserted during WAIT SHALL drop mem_req immediately, discard the instruction, and leave sp at SP_RESET; a late mem_ack after release SHALL be ignored.

Structure
REQ-043 A shared package SHALL hold the opcode enum (NOP..POP), DATA_W, ADDR_W, and SP_RESET.
REQ-044 A single sub-module, stack_ptr, SHALL hold the sp register and its +1/-1 modulo update and expose sp and sp+1.

Verification
REQ-045 Reset, then LDM in_value = 16'hBEEF, rdst = 3, ccr = 3'b101 -> next cycle out_valid = 1, out_result = 16'hBEEF, out_wb_en = 1, out_rdst = 3, out_ccr = 3'b101.
REQ-046 STD addr 16'h0010 data 16'h1234 with ack after 3 cycles, then LDD addr 16'h0010 -> mem_req held for 3 cycles with we = 1, in_ready = 0 throughout, and the LDD returns out_result = 16'h1234.
REQ-047 PUSH 16'hAAAA then POP -> write at 11'h7FF with sp becoming 11'h7FE, read at 11'h7FF with sp back to 11'h7FF and out_result = 16'hAAAA.
REQ-048 POP directly after reset -> mem_addr = 0 and sp wraps to 0.
REQ-049 Hold mem_ack = 1 for several cycles in IDLE, then assert rst_n = 0 mid-WAIT -> no spurious out_valid, mem_req falls asynchronously, and sp = 11'h7FF.
REQ-050 Issue in_op = 7 -> out_valid pulses with out_wb_en = 0 and no mem_req is raised.
